shift_expander: RTL and testbench



---
 rtl/shift_expander.sv | 72 +++++++
 tb/tb_shift_expander.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/shift_expander.sv
// Serial-in / parallel-out shift register with parallel load, a registered
// cascade output, a frame counter and either a latched or a gated parallel view.
module shift_expander #(
  parameter int WIDTH     = 10,
  parameter bit LATCH_OUT = 1'b1
) (
  input  logic                     cp,
  input  logic                     rst,
  input  logic                     data,
  input  logic                     shift,
  input  logic                     load,
  input  logic [WIDTH-1:0]         d_in,
  input  logic                     e,
  output logic [WIDTH-1:0]         p_out,
  output logic                     s_out,
  output logic                     frame_done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;

  // load wins over shift; s_out only moves on a true shift edge
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      s_out      <= 1'b0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        sr      <= d_in;
        bit_cnt <= '0;
      end else if (shift) begin
        sr    <= {sr[WIDTH-2:0], data};
        s_out <= sr[WIDTH-1];
        if (bit_cnt == CNT_LAST) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  generate
    if (LATCH_OUT) begin : g_latched
      logic [WIDTH-1:0] olat;

      always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
          olat <= '0;
        end else if (e) begin
          olat <= sr;
        end
      end

      always_comb begin
        p_out = olat;
      end
    end else begin : g_live
      always_comb begin
        p_out = e ? sr : '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_shift_expander.sv
// Directed bench: a latched and a live instance share stimulus; a second
// latched stage is cascaded from the live instance's s_out.
module tb_shift_expander;

  localparam int W = 10;

  logic         cp = 1'b0;
  logic         rst;
  logic         data;
  logic         shift;
  logic         load;
  logic [W-1:0] d_in;
  logic         e;

  logic [W-1:0] lat_p, live_p, s2_p;
  logic         lat_s, live_s, s2_s;
  logic         lat_fd, live_fd, s2_fd;
  logic [3:0]   lat_cnt, live_cnt, s2_cnt;

  int checks = 0;
  int errors = 0;

  always #5 cp = ~cp;

  shift_expander #(.WIDTH(W), .LATCH_OUT(1'b1)) u_lat (
    .cp(cp), .rst(rst), .data(data), .shift(shift), .load(load), .d_in(d_in), .e(e),
    .p_out(lat_p), .s_out(lat_s), .frame_done(lat_fd), .bit_cnt(lat_cnt)
  );

  shift_expander #(.WIDTH(W), .LATCH_OUT(1'b0)) u_live (
    .cp(cp), .rst(rst), .data(data), .shift(shift), .load(load), .d_in(d_in), .e(e),
    .p_out(live_p), .s_out(live_s), .frame_done(live_fd), .bit_cnt(live_cnt)
  );

  shift_expander #(.WIDTH(W), .LATCH_OUT(1'b1)) u_s2 (
    .cp(cp), .rst(rst), .data(live_s), .shift(shift), .load(load), .d_in(d_in), .e(e),
    .p_out(s2_p), .s_out(s2_s), .frame_done(s2_fd), .bit_cnt(s2_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  initial begin
    rst = 1'b1; data = 1'b0; shift = 1'b0; load = 1'b0; d_in = '0; e = 1'b0;
    #1;
    check("rst_lat_p", 32'(lat_p), 0);
    check("rst_live_p", 32'(live_p), 0);
    check("rst_s_out", 32'(lat_s), 0);
    check("rst_fd", 32'(lat_fd), 0);
    check("rst_cnt", 32'(lat_cnt), 0);
    check("rst_s2", 32'({s2_p, s2_s, s2_fd, s2_cnt}), 0);

    // single 1 injected, then zeros; s_out rises after edge 11
    rst = 1'b0; shift = 1'b1; data = 1'b1;
    step();
    data = 1'b0;
    check("sc1_cnt_e1", 32'(live_cnt), 1);
    for (int n = 2; n <= 9; n++) begin
      step();
      check("sc1_s_out_lo", 32'(live_s), 0);
      check("sc1_fd_lo", 32'(live_fd), 0);
      check("sc1_cnt", 32'(live_cnt), 32'(n));
    end
    step();
    check("sc1_fd_e10", 32'(live_fd), 1);
    check("sc1_cnt_e10", 32'(live_cnt), 0);
    check("sc1_s_out_e10", 32'(live_s), 0);
    step();
    check("sc1_s_out_e11", 32'(live_s), 1);
    check("sc1_fd_e11", 32'(live_fd), 0);
    check("sc1_cnt_e11", 32'(live_cnt), 1);
    step();
    check("sc1_s_out_e12", 32'(live_s), 0);

    // load 2A5, then capture with e during a shift edge
    shift = 1'b0; load = 1'b1; d_in = 10'h2A5;
    step();
    load = 1'b0;
    check("sc2_cnt_load", 32'(live_cnt), 0);
    check("sc2_live_gated", 32'(live_p), 0);
    e = 1'b1; shift = 1'b1; data = 1'b0;
    #1;
    check("sc2_live_view", 32'(live_p), 32'h2A5);
    step();
    check("sc2_olat_preshift", 32'(lat_p), 32'h2A5);
    check("sc2_sr_shifted", 32'(live_p), 32'h14A);
    e = 1'b0;
    for (int n = 2; n <= 10; n++) step();
    check("sc2_olat_hold", 32'(lat_p), 32'h2A5);
    check("sc2_fd", 32'(live_fd), 1);
    check("sc2_s_out", 32'(live_s), 1);
    e = 1'b1;
    #1;
    check("sc2_sr_empty", 32'(live_p), 0);

    // idle edge, then load and shift together
    shift = 1'b0;
    step();
    check("sc3_idle_fd", 32'(live_fd), 0);
    check("sc3_idle_s_out", 32'(live_s), 1);
    check("sc3_idle_olat", 32'(lat_p), 0);
    load = 1'b1; shift = 1'b1; d_in = 10'h3FF; data = 1'b0;
    step();
    load = 1'b0; shift = 1'b0;
    check("sc3_sr", 32'(live_p), 32'h3FF);
    check("sc3_cnt", 32'(live_cnt), 0);
    check("sc3_s_out", 32'(live_s), 1);
    check("sc3_fd", 32'(live_fd), 0);

    // 4 shifts, then asynchronous reset mid-cycle
    shift = 1'b1; data = 1'b1;
    for (int n = 1; n <= 4; n++) step();
    check("sc4_cnt", 32'(live_cnt), 4);
    check("sc4_olat", 32'(lat_p), 32'h3FF);
    check("sc4_s_out", 32'(live_s), 1);
    rst = 1'b1;
    #1;
    check("sc4_async_lat_p", 32'(lat_p), 0);
    check("sc4_async_live_p", 32'(live_p), 0);
    check("sc4_async_s_out", 32'(live_s), 0);
    check("sc4_async_cnt", 32'(live_cnt), 0);
    load = 1'b1; d_in = 10'h3FF;
    step();
    check("sc4_held_all", 32'({lat_p, live_p, live_s, live_fd, live_cnt}), 0);
    load = 1'b0; data = 1'b0;
    rst = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      step();
      check("sc4_fd_early", 32'(live_fd), 0);
    end
    step();
    check("sc4_fd_e10", 32'(live_fd), 1);

    // live view toggled by e alone
    shift = 1'b0; load = 1'b1; d_in = 10'h155; e = 1'b0;
    step();
    load = 1'b0;
    check("sc5_e0", 32'(live_p), 0);
    e = 1'b1;
    #1;
    check("sc5_e1", 32'(live_p), 32'h155);
    e = 1'b0;
    #1;
    check("sc5_e0b", 32'(live_p), 0);
    e = 1'b1;
    #1;
    check("sc5_e1b", 32'(live_p), 32'h155);

    // two-stage cascade, one 1-bit injected at edge 1
    e = 1'b0; rst = 1'b1;
    #1;
    rst = 1'b0; shift = 1'b1; data = 1'b1;
    step();
    data = 1'b0;
    for (int n = 2; n <= 21; n++) begin
      step();
      check("sc6_s2_lo", 32'(s2_s), 0);
    end
    step();
    check("sc6_s2_e22", 32'(s2_s), 1);
    step();
    check("sc6_s2_e23", 32'(s2_s), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
